// File: rtl/aes_pkg.sv
// Shared AES types, widths, FSM encoding and the FIPS-197 forward S-box table.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W   = 128;
    localparam int unsigned AES_BYTE_W    = 8;
    localparam int unsigned AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;
    localparam int unsigned AES_IDX_W     = $clog2(AES_NUM_BYTES);

    typedef logic [AES_NUM_BYTES-1:0][AES_BYTE_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        PIPE = 2'd2,
        DONE = 2'd3
    } aes_state_e;

    localparam logic [AES_BYTE_W-1:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox_fun.sv
// Combinational 8-bit forward S-box lookup.
module aes_sbox_fun
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] inData,
    output logic [AES_BYTE_W-1:0] outData
);

    assign outData = SBOX_FWD[inData];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential forward SubBytes: LANES bytes per cycle over valid/ready handshakes.
// Define AES_SBOX_PIPE_EN to register S-box outputs before write-back (adds PIPE state).
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [AES_BLOCK_W-1:0] inData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [AES_BLOCK_W-1:0] outData
);

    localparam int unsigned N     = AES_NUM_BYTES / LANES;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    aes_state_e                            state_q, state_d;
    logic       [CNT_W-1:0]                cnt_q, cnt_d;
    aes_block_t                            data_q, data_d;
    logic                                  in_ready_q, in_ready_d;
    logic                                  out_valid_q, out_valid_d;
    logic       [LANES-1:0][AES_BYTE_W-1:0] lut_out;
    logic                                  wr_en;
    logic       [CNT_W-1:0]                wr_cnt;
    logic       [LANES-1:0][AES_BYTE_W-1:0] wr_bytes;
    logic       [AES_IDX_W-1:0]            wr_idx;
    logic                                  accept;

    // in_ready_q is only ever set in IDLE, so it alone qualifies a load
    assign accept   = inValid && in_ready_q;
    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign outData  = data_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [AES_IDX_W-1:0] rd_idx;
        assign rd_idx = AES_IDX_W'(32'(cnt_q) * LANES + 32'(g));
        aes_sbox_fun u_sbox (
            .inData  (data_q[rd_idx]),
            .outData (lut_out[g])
        );
    end

`ifdef AES_SBOX_PIPE_EN
    logic [LANES-1:0][AES_BYTE_W-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]                 pipe_cnt_q, pipe_cnt_d;
    logic                             pipe_vld_q, pipe_vld_d;

    // Lookup results land here and are written back one cycle later
    always_comb begin
        pipe_d     = lut_out;
        pipe_cnt_d = cnt_q;
        pipe_vld_d = (state_q == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            pipe_q     <= '0;
            pipe_cnt_q <= '0;
            pipe_vld_q <= 1'b0;
        end else begin
            pipe_q     <= pipe_d;
            pipe_cnt_q <= pipe_cnt_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    assign wr_en    = pipe_vld_q;
    assign wr_cnt   = pipe_cnt_q;
    assign wr_bytes = pipe_q;
`else
    assign wr_en    = (state_q == BUSY);
    assign wr_cnt   = cnt_q;
    assign wr_bytes = lut_out;
`endif

    // Next state, chunk counter and registered handshake flags
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef AES_SBOX_PIPE_EN
                    state_d = PIPE;
`else
                    state_d = DONE;
`endif
                end
            end
            PIPE: begin
                state_d = DONE;
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State register: load on accept, otherwise in-place chunk write-back
    always_comb begin
        data_d = data_q;
        wr_idx = '0;
        if (accept) begin
            data_d = aes_block_t'(inData);
        end else if (wr_en) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                wr_idx         = AES_IDX_W'(32'(wr_cnt) * LANES + l);
                data_d[wr_idx] = wr_bytes[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/aes_sub_bytes_seq.md
# aes_sub_bytes_seq

Sequential forward SubBytes unit for the encryption datapath. It accepts one 128-bit AES state over a valid/ready handshake and applies the FIPS-197 forward S-box to all 16 bytes, `LANES` bytes per clock. It returns the substituted state over a second valid/ready handshake. It is the encrypt-direction counterpart of the inverse S-box used on the decrypt path and sits between AddRoundKey and ShiftRows in the iterative round engine.

## Interface
- `LANES`, default 4: S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16. `N = 16/LANES` processing cycles.
- `clk`  in  1  clock, all logic on rising edge
- `nRst`  in  1  reset; one clock; reset is synchronous and active-low
- `inValid`  in  1  input block valid
- `inReady`  out  1  unit can accept a block
- `inData`  in  128  input state; byte i = `inData[8i+7:8i]`
- `outValid`  out  1  substituted block available
- `outReady`  in  1  downstream accepts block
- `outData`  out  128  substituted state, same byte mapping

## Operation
- FSM states:
  - IDLE: `inReady=1`. Goes to BUSY on `inValid&&inReady`, which loads `inData` into the state register and clears the chunk counter.
  - BUSY: each cycle, bytes `cnt*LANES .. cnt*LANES+LANES-1` of the state register are replaced in place by S(byte), then `cnt` increments. When `cnt==N-1`, goes to DONE, or to PIPE when `AES_SBOX_PIPE_EN` is defined.
  - PIPE (only when the macro is defined): one cycle while the final registered chunk is written back. Then goes to DONE.
  - DONE: `outValid=1` and `outData` = state register. Goes to IDLE on `outReady`.
- `cnt` width is `$clog2(N)`, with a minimum of 1 bit. `cnt` wraps to 0 on entry to IDLE.
- Chunks are processed lowest byte indices first.
- The S-box is the standard FIPS-197 forward table, for example S(00)=63, S(53)=ED, S(FF)=16.
- `inValid` in BUSY, PIPE or DONE is ignored. `inReady=0` in those states and no data is captured.
- `outData` holds stable while `outValid=1` and `outReady=0`. It keeps the last result after the handshake until the next load overwrites it.
- `inValid` and `inData` changes while `inReady=0` have no effect.

## Timing
- Reset (`nRst=0` at an edge) forces:
  - state IDLE, `cnt=0`, state register and `outData` 128'h0, `outValid=0`
  - `inReady=0` while `nRst` is low; `inReady=1` from the first cycle after release
- Reset in BUSY, PIPE or DONE aborts the block with no output.
- Latency from the accepting edge to `outValid` high:
  - N cycles without `AES_SBOX_PIPE_EN` (LANES=4 gives 4)
  - N+1 cycles with it
- Minimum block period is N+2 cycles, or N+3 with the macro. This covers load, N processing cycles, optional PIPE, the DONE handshake and the return to IDLE.
- `inReady` and `outValid` are decoded from registered state only, with no combinational path from inputs.
- Back-to-back: `outReady` held high gives `outValid` for exactly one cycle, and `inReady` reasserts on the next cycle.

## Configuration
- `AES_SBOX_PIPE_EN` defined:
  - S-box outputs are registered before write-back, to shorten the critical path for high-frequency targets
  - adds the PIPE state and one latency cycle
  - write-back of chunk k occurs one cycle after its lookup
- Macro undefined:
  - lookup and write-back happen in the same cycle
  - no PIPE state
  - latency N

## Structure
- The shared package `aes_pkg` holds:
  - FSM state enum (IDLE, BUSY, PIPE, DONE)
  - `AES_BLOCK_W=128`, `AES_BYTE_W=8`
  - forward S-box constant table, used by `aes_sbox_fun`
- Sub-module `aes_sbox_fun`: combinational 8-bit forward S-box, ports `inData[7:0]` and `outData[7:0]`. It is instantiated `LANES` times via generate.
- The top level holds the FSM, counter, state register, chunk mux and demux, and the optional pipe register.

## Test plan
- Reset mid-BUSY: load a block, assert `nRst=0` after 2 cycles, then release. Required: `outValid` stays 0, `outData=0`, `inReady=1` one cycle after release, and the next block processes correctly.
- FIPS-197 round-1 vector: load `inData` bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08. Required: output bytes d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, with `outValid` exactly 4 cycles after the accept edge (5 cycles with the macro).
- All-zero and all-FF inputs: 128'h0 gives all bytes 63; all-FF gives all bytes 16.
- Backpressure: hold `outReady=0` for 10 cycles in DONE. Required: `outData` stable, `inReady=0`, and a second `inValid` pulse is ignored. After `outReady` rises, the second block is accepted only once back in IDLE.
- Exhaustive byte sweep: 16 blocks cover values 00..FF with LANES=1, 4 and 16. Required: each output byte matches the table. Passing each output through the inverse S-box on the bench recovers the input.
- Throughput: stream 8 blocks with `inValid` and `outReady` tied high. Required: one result every N+2 cycles (N+3 with the macro), in order, with no drops.
